// File: rtl/aud_pkg.sv
// Shared types and defaults for the audio player stream.
//   aud_mode_e     : serial framing (I2S with one-bit delay, or left-justified)
//   player_state_e : serializer FSM states
//   AUD_*_DEF      : default parameter values
package aud_pkg;

  typedef enum logic {
    AUD_I2S = 1'b0,
    AUD_LJ  = 1'b1
  } aud_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_L,
    ST_DELAY,
    ST_SHIFT,
    ST_PAD
  } player_state_e;

  localparam int unsigned AUD_DATA_W_DEF     = 16;
  localparam int unsigned AUD_FIFO_DEPTH_DEF = 4;
  localparam int unsigned AUD_CNT_W_DEF      = 16;

endpackage

// File: rtl/aud_sample_fifo.sv
// Synchronous show-ahead FIFO for packed stereo pairs.
//   clk, rst        : clock, synchronous active-high reset
//   push, wr_data   : write request (ignored when full)
//   pop, rd_data    : read request (ignored when empty); rd_data shows the head
//   full, empty     : occupancy flags
//   level           : current number of entries
module aud_sample_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (level == (AW+1)'(DEPTH));
    empty   = (level == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rd_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/aud_player_stream.sv
// Stereo sample stream to WM8731 DACDAT serializer, BCLK domain.
//   i_bclk, i_rst          : bit clock, synchronous active-high reset
//   i_daclrck              : codec LR clock (0 = left, 1 = right)
//   i_en, i_mode           : playback enable; framing (0 I2S, 1 left-justified)
//   i_valid/o_ready        : sample-pair stream handshake, i_data_l/i_data_r
//   o_aud_dacdat           : registered serial data, MSB first
//   o_fifo_level           : FIFO occupancy
//   o_underrun_cnt         : left frames started with an empty FIFO (saturating)
//   o_short_cnt            : half-frames cut before all bits were sent (saturating)
module aud_player_stream
  import aud_pkg::*;
#(
  parameter int unsigned DATA_W     = AUD_DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = AUD_FIFO_DEPTH_DEF,
  parameter int unsigned CNT_W      = AUD_CNT_W_DEF
) (
  input  logic                          i_bclk,
  input  logic                          i_rst,
  input  logic                          i_daclrck,
  input  logic                          i_en,
  input  logic                          i_mode,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [DATA_W-1:0]             i_data_l,
  input  logic [DATA_W-1:0]             i_data_r,
  output logic                          o_aud_dacdat,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [CNT_W-1:0]              o_underrun_cnt,
  output logic [CNT_W-1:0]              o_short_cnt
);

  localparam int unsigned BCNT_W = $clog2(DATA_W + 1);

  player_state_e       state;
  aud_mode_e           mode_q;
  aud_mode_e           start_mode;
  logic                lrck_d;
  logic                left_edge, right_edge, any_edge;
  logic                active;
  logic                push, pop;
  logic                fifo_full, fifo_empty;
  logic [2*DATA_W-1:0] fifo_rd;
  logic [DATA_W-1:0]   pop_l, pop_r;
  logic [DATA_W-1:0]   hold_r;
  logic [DATA_W-1:0]   sreg;
  logic [DATA_W-1:0]   start_sample;
  logic [BCNT_W-1:0]   bits_left;
  logic                start_half, go_idle, short_evt, underrun_evt;

  aud_sample_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_bclk),
    .rst     (i_rst),
    .push    (push),
    .wr_data ({i_data_l, i_data_r}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_fifo_level)
  );

  always_comb begin
    left_edge    = lrck_d & ~i_daclrck;
    right_edge   = ~lrck_d & i_daclrck;
    any_edge     = left_edge | right_edge;
    active       = state inside {ST_DELAY, ST_SHIFT, ST_PAD};
    o_ready      = !fifo_full;
    push         = i_valid && !fifo_full;
    // A left edge pops whenever enabled and out of IDLE (WAIT_L or playing).
    pop          = left_edge && i_en && (state != ST_IDLE);
    underrun_evt = pop && fifo_empty;
    pop_l        = fifo_empty ? '0 : fifo_rd[2*DATA_W-1:DATA_W];
    pop_r        = fifo_empty ? '0 : fifo_rd[DATA_W-1:0];
    // Right half always completes once a left half has started, even if
    // i_en dropped; the enable is only honoured at left edges.
    start_half   = pop || (active && right_edge);
    go_idle      = !i_en && ((state == ST_WAIT_L) || (active && left_edge));
    start_mode   = left_edge ? aud_mode_e'(i_mode) : mode_q;
    start_sample = left_edge ? pop_l : hold_r;
    short_evt    = any_edge && ((state == ST_DELAY) || (state == ST_SHIFT));
  end

  always_ff @(posedge i_bclk) begin
    if (i_rst) begin
      state          <= ST_IDLE;
      mode_q         <= AUD_I2S;
      lrck_d         <= 1'b0;
      o_aud_dacdat   <= 1'b0;
      sreg           <= '0;
      bits_left      <= '0;
      hold_r         <= '0;
      o_underrun_cnt <= '0;
      o_short_cnt    <= '0;
    end else begin
      lrck_d <= i_daclrck;
      if (underrun_evt && !(&o_underrun_cnt)) o_underrun_cnt <= o_underrun_cnt + 1'b1;
      if (short_evt && !(&o_short_cnt))       o_short_cnt    <= o_short_cnt + 1'b1;

      if (start_half) begin
        if (left_edge) begin
          mode_q <= start_mode;
          hold_r <= pop_r;
        end
        if (start_mode == AUD_LJ) begin
          // MSB leaves on the edge cycle; the rest shift out from SHIFT.
          o_aud_dacdat <= start_sample[DATA_W-1];
          sreg         <= start_sample << 1;
          bits_left    <= BCNT_W'(DATA_W - 1);
          state        <= ST_SHIFT;
        end else begin
          o_aud_dacdat <= 1'b0;
          sreg         <= start_sample;
          bits_left    <= BCNT_W'(DATA_W);
          state        <= ST_DELAY;
        end
      end else if (go_idle) begin
        o_aud_dacdat <= 1'b0;
        state        <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            o_aud_dacdat <= 1'b0;
            if (i_en) state <= ST_WAIT_L;
          end
          ST_WAIT_L, ST_PAD: o_aud_dacdat <= 1'b0;
          ST_DELAY, ST_SHIFT: begin
            o_aud_dacdat <= sreg[DATA_W-1];
            sreg         <= sreg << 1;
            bits_left    <= bits_left - 1'b1;
            state        <= (bits_left == BCNT_W'(1)) ? ST_PAD : ST_SHIFT;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aud_player_stream.sv
// Scoreboard bench for aud_player_stream: a queue-based reference model
// predicts every cycle's outputs; a monitor compares them after each edge.
module tb_aud_player_stream;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_PLAY = 2;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          lrck  = 1'b0;
  logic          en    = 1'b0;
  logic          mode  = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] dl    = '0;
  logic [DW-1:0] dr    = '0;
  logic          ready;
  logic          dacdat;
  logic [2:0]    level;
  logic [CW-1:0] under_cnt;
  logic [CW-1:0] short_cnt;

  aud_player_stream #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .i_bclk         (clk),
    .i_rst          (rst),
    .i_daclrck      (lrck),
    .i_en           (en),
    .i_mode         (mode),
    .i_valid        (valid),
    .o_ready        (ready),
    .i_data_l       (dl),
    .i_data_r       (dr),
    .o_aud_dacdat   (dacdat),
    .o_fifo_level   (level),
    .o_underrun_cnt (under_cnt),
    .o_short_cnt    (short_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dac;
    int lvl;
    int rdy;
    int under;
    int shrt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2*DW-1:0] mq[$];
  bit              m_bits[$];
  int              m_delay, m_out, m_under, m_short, m_phase;
  bit              m_prev, m_mode_l;
  logic [DW-1:0]   m_r;

  function automatic int sat(int v);
    return (v < (1 << CW) - 1) ? v + 1 : v;
  endfunction

  task automatic m_emit();
    if (m_delay > 0) begin
      m_delay--;
      m_out = 0;
    end else if (m_bits.size() > 0) m_out = int'(m_bits.pop_front());
    else m_out = 0;
  endtask

  task automatic m_start(logic [DW-1:0] s);
    m_bits.delete();
    for (int i = DW - 1; i >= 0; i--) m_bits.push_back(s[i]);
    m_delay = m_mode_l ? 0 : 1;
    m_emit();
  endtask

  task automatic model_step();
    bit            le, re, room;
    logic [DW-1:0] pl, pr;
    exp_t          e;
    if (rst) begin
      mq.delete();
      m_bits.delete();
      m_prev = 0; m_phase = M_IDLE; m_mode_l = 0; m_r = '0;
      m_delay = 0; m_out = 0; m_under = 0; m_short = 0;
    end else begin
      le = m_prev && !lrck;
      re = !m_prev && lrck;
      room = mq.size() < DEPTH;
      pl = '0; pr = '0;
      if (le && en && m_phase != M_IDLE) begin
        if (mq.size() == 0) m_under = sat(m_under);
        else {pl, pr} = mq.pop_front();
      end
      if (valid && room) mq.push_back({dl, dr});
      if ((le || re) && m_phase == M_PLAY && (m_delay > 0 || m_bits.size() > 0))
        m_short = sat(m_short);
      case (m_phase)
        M_IDLE: begin
          m_out = 0;
          if (en) m_phase = M_WAIT;
        end
        M_WAIT: begin
          if (!en) begin m_phase = M_IDLE; m_out = 0; end
          else if (le) begin
            m_mode_l = mode; m_r = pr; m_start(pl); m_phase = M_PLAY;
          end else m_out = 0;
        end
        default: begin
          if (le && !en) begin
            m_phase = M_IDLE; m_out = 0; m_bits.delete(); m_delay = 0;
          end else if (le) begin
            m_mode_l = mode; m_r = pr; m_start(pl);
          end else if (re) m_start(m_r);
          else m_emit();
        end
      endcase
      m_prev = lrck;
    end
    e.dac = m_out; e.lvl = mq.size(); e.rdy = (mq.size() < DEPTH) ? 1 : 0;
    e.under = m_under; e.shrt = m_short;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("dacdat",       32'(dacdat),    32'(e.dac));
      chk("fifo_level",   32'(level),     32'(e.lvl));
      chk("ready",        32'(ready),     32'(e.rdy));
      chk("underrun_cnt", 32'(under_cnt), 32'(e.under));
      chk("short_cnt",    32'(short_cnt), 32'(e.shrt));
    end
  end

  // ---------------- stimulus ----------------
  int hp = 32;
  int lr_cnt = 0;
  bit lr_run = 0;
  bit rand_hp = 0;

  task automatic tick();
    if (lr_run) begin
      if (lr_cnt == hp - 1) begin
        lrck = ~lrck;
        lr_cnt = 0;
        if (rand_hp) hp = $urandom_range(8, 40);
      end else lr_cnt++;
    end
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1; lr_run = 0; lrck = 1'b0; lr_cnt = 0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic push_pair(logic [DW-1:0] l, logic [DW-1:0] r);
    valid = 1'b1; dl = l; dr = r;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    // reset values
    do_reset(4);
    chk("rst_dacdat", 32'(dacdat), 0);
    chk("rst_level",  32'(level),  0);
    chk("rst_ready",  32'(ready),  1);
    chk("rst_under",  32'(under_cnt), 0);
    chk("rst_short",  32'(short_cnt), 0);

    // I2S basic
    en = 1'b1; mode = 1'b0;
    push_pair(16'hA5C3, 16'h0F0F);
    chk("i2s_level_pre", 32'(level), 1);
    hp = 32; lr_run = 1;
    repeat (70) tick();
    chk("i2s_level_post", 32'(level), 0);
    repeat (60) tick();

    // left-justified
    do_reset(2);
    en = 1'b1; mode = 1'b1;
    push_pair(16'hA5C3, 16'h0F0F);
    hp = 32; lr_run = 1;
    repeat (130) tick();

    // underrun: three empty left frames, then a pair plays
    do_reset(2);
    en = 1'b1; mode = 1'b0;
    hp = 32; lr_run = 1;
    repeat (200) tick();
    chk("underrun_3", 32'(under_cnt), 3);
    push_pair(DW'($urandom), DW'($urandom));
    repeat (80) tick();

    // backpressure with static LRCK
    do_reset(2);
    en = 1'b0; lrck = 1'b1;
    for (int i = 0; i < 6; i++) push_pair(DW'($urandom), DW'($urandom));
    chk("bp_level_full", 32'(level), 4);
    chk("bp_ready_low",  32'(ready), 0);
    en = 1'b1;
    tick(); tick();
    lrck = 1'b0;
    tick();
    chk("bp_level_pop", 32'(level), 3);
    chk("bp_ready_up",  32'(ready), 1);
    hp = 32; lr_cnt = 0; lr_run = 1;
    repeat (100) tick();

    // short frames in I2S
    do_reset(2);
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 3; i++) push_pair(DW'($urandom), DW'($urandom));
    hp = 10; lr_run = 1;
    repeat (120) tick();

    // reset mid-shift discards FIFO contents
    do_reset(2);
    en = 1'b1; mode = 1'b0;
    push_pair(16'h8001, 16'h7FFE);
    push_pair(16'h1234, 16'hFEDC);
    hp = 32; lr_run = 1;
    repeat (72) tick();
    do_reset(1);
    chk("midrst_dacdat", 32'(dacdat), 0);
    chk("midrst_level",  32'(level),  0);
    chk("midrst_under",  32'(under_cnt), 0);
    chk("midrst_short",  32'(short_cnt), 0);

    // disable mid-left: right half still plays, FIFO retained
    do_reset(1);
    en = 1'b1; mode = 1'b0;
    push_pair(16'hC0DE, 16'hBEEF);
    push_pair(16'h5555, 16'hAAAA);
    hp = 32; lr_run = 1;
    repeat (72) tick();
    en = 1'b0;
    repeat (80) tick();
    chk("disable_level", 32'(level), 1);

    // randomized traffic
    do_reset(2);
    en = 1'b1; rand_hp = 1; lr_run = 1;
    for (int n = 0; n < 4000; n++) begin
      valid = ($urandom % 3) == 0;
      dl = DW'($urandom);
      dr = DW'($urandom);
      if ($urandom % 150 == 0) en = ~en;
      if ($urandom % 60 == 0) mode = 1'($urandom);
      rst = ($urandom % 1500) == 0;
      tick();
    end
    rst = 1'b0; valid = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
